// File: rtl/trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trace_pkg                                                    |
// | Description : Shared types and defaults for the DPLL assignment trail.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package trace_pkg;

    localparam int VAR_W_DEF = 9;
    localparam int DEPTH_DEF = 512;

    localparam logic DECIDE = 1'b0;
    localparam logic FORCED = 1'b1;

    // 'var' is a reserved word, hence var_idx for the variable index field
    typedef struct packed {
        logic                 typ;
        logic                 val;
        logic [VAR_W_DEF-1:0] var_idx;
    } trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/trace_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trace_mem                                                    |
// | Description : Single-port RAM, synchronous write, registered read.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module trace_mem
    import trace_pkg::*;
#(
    parameter int WIDTH = $bits(trace_entry_t),
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Read register only loads on a read, so it holds the last popped entry
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/trace_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trace_table                                                  |
// | Description : LIFO trail of variable assignments with 1-cycle pop latency. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module trace_table
    import trace_pkg::*;
#(
    parameter int VAR_W = VAR_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             rw,
    input  logic             type_in,
    input  logic             val,
    input  logic [VAR_W-1:0] variable,
    output logic             type_out,
    output logic             val_out,
    output logic [VAR_W-1:0] variable_out,
    output logic             empty
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;
    localparam int EW  = VAR_W + 2;

    logic [SPW-1:0] r_sp;
    logic           r_out_valid;
    logic           w_push;
    logic           w_pop;
    logic [AW-1:0]  w_addr;
    logic [EW-1:0]  w_rdata;

    assign w_push = reset && en &&  rw && (r_sp < SPW'(DEPTH));
    assign w_pop  = reset && en && !rw && (r_sp != '0);
    assign w_addr = w_push ? r_sp[AW-1:0] : (r_sp[AW-1:0] - AW'(1));
    assign empty  = (r_sp == '0);

    trace_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clock),
        .i_we    (w_push),
        .i_re    (w_pop),
        .i_addr  (w_addr),
        .i_wdata ({type_in, val, variable}),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sp        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_sp <= r_sp + SPW'(1);
            end else if (w_pop) begin
                r_sp <= r_sp - SPW'(1);
            end
            if (w_pop) begin
                r_out_valid <= 1'b1;
            end
        end
    end

    // RAM contents survive reset, so outputs are forced to zero until a pop
    assign {type_out, val_out, variable_out} = r_out_valid ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_trace_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_trace_table                                               |
// | Description : Self-checking bench: vector table plus stack scoreboard.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_trace_table;
    import trace_pkg::*;

    localparam int DP = 512;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       en       = 1'b0;
    logic       rw       = 1'b0;
    logic       type_in  = 1'b0;
    logic       val      = 1'b0;
    logic [8:0] variable = '0;
    logic       type_out;
    logic       val_out;
    logic [8:0] variable_out;
    logic       empty;

    always #5 clock = ~clock;

    trace_table #(
        .VAR_W (9),
        .DEPTH (DP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .en           (en),
        .rw           (rw),
        .type_in      (type_in),
        .val          (val),
        .variable     (variable),
        .type_out     (type_out),
        .val_out      (val_out),
        .variable_out (variable_out),
        .empty        (empty)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    trace_entry_t  model_stack[$];
    trace_entry_t  sb[$];
    trace_entry_t  exp_out = '0;

    typedef struct {
        logic         en;
        logic         rw;
        trace_entry_t ent;
        trace_entry_t exp_out;
        logic         exp_empty;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clock);
        reset = 1'b0;
        en    = 1'b0;
        repeat (cycles) @(posedge clock);
        #1;
        reset = 1'b1;
        model_stack.delete();
        sb.delete();
        exp_out = '0;
    endtask

    // Drives one operation, updates the reference stack, checks after the edge
    task automatic op(input logic e, input logic w, input trace_entry_t ent, input string name);
        @(negedge clock);
        en = e;
        rw = w;
        {type_in, val, variable} = ent;
        if (e && w && model_stack.size() < DP) begin
            model_stack.push_back(ent);
        end else if (e && !w && model_stack.size() > 0) begin
            sb.push_back(model_stack.pop_back());
        end
        @(posedge clock);
        #1;
        if (sb.size() > 0) exp_out = sb.pop_front();
        check({name, " out"}, 32'({type_out, val_out, variable_out}), 32'(exp_out));
        check({name, " empty"}, 32'(empty), 32'(model_stack.size() == 0));
        en = 1'b0;
    endtask

    function automatic trace_entry_t mk(input logic t, input logic v, input logic [8:0] x);
        trace_entry_t r;
        r.typ     = t;
        r.val     = v;
        r.var_idx = x;
        return r;
    endfunction

    initial begin
        trace_entry_t e;

        tbl[0]  = '{1'b1, 1'b1, mk(DECIDE, 1, 9'd5),   mk(0, 0, 9'd0),        1'b0};
        tbl[1]  = '{1'b1, 1'b0, mk(0, 0, 9'd0),        mk(DECIDE, 1, 9'd5),   1'b1};
        tbl[2]  = '{1'b1, 1'b1, mk(DECIDE, 1, 9'd3),   mk(DECIDE, 1, 9'd5),   1'b0};
        tbl[3]  = '{1'b1, 1'b1, mk(FORCED, 0, 9'd7),   mk(DECIDE, 1, 9'd5),   1'b0};
        tbl[4]  = '{1'b1, 1'b1, mk(FORCED, 1, 9'd511), mk(DECIDE, 1, 9'd5),   1'b0};
        tbl[5]  = '{1'b1, 1'b0, mk(0, 0, 9'd0),        mk(FORCED, 1, 9'd511), 1'b0};
        tbl[6]  = '{1'b1, 1'b0, mk(0, 0, 9'd0),        mk(FORCED, 0, 9'd7),   1'b0};
        tbl[7]  = '{1'b1, 1'b0, mk(0, 0, 9'd0),        mk(DECIDE, 1, 9'd3),   1'b1};
        tbl[8]  = '{1'b1, 1'b0, mk(1, 1, 9'd77),       mk(DECIDE, 1, 9'd3),   1'b1};
        tbl[9]  = '{1'b0, 1'b1, mk(1, 1, 9'd88),       mk(DECIDE, 1, 9'd3),   1'b1};
        tbl[10] = '{1'b1, 1'b1, mk(FORCED, 0, 9'd42),  mk(DECIDE, 1, 9'd3),   1'b0};
        tbl[11] = '{1'b0, 1'b0, mk(0, 1, 9'd13),       mk(DECIDE, 1, 9'd3),   1'b0};
        tbl[12] = '{1'b1, 1'b0, mk(0, 0, 9'd0),        mk(FORCED, 0, 9'd42),  1'b1};

        // Reset held for two cycles
        apply_reset(2);
        check("reset empty", 32'(empty), 32'd1);
        check("reset out", 32'({type_out, val_out, variable_out}), 32'd0);

        // Single push/pop, ordering, empty pop, en=0 hold
        for (int i = 0; i < 13; i++) begin
            op(tbl[i].en, tbl[i].rw, tbl[i].ent, $sformatf("vec%0d", i));
            check($sformatf("vec%0d tbl out", i),
                  32'({type_out, val_out, variable_out}), 32'(tbl[i].exp_out));
            check($sformatf("vec%0d tbl empty", i), 32'(empty), 32'(tbl[i].exp_empty));
        end

        // Fill to capacity, overflow push, full drain
        for (int i = 0; i < DP; i++) begin
            e = mk(i[0], i[1], i[8:0]);
            op(1'b1, 1'b1, e, "fill");
        end
        op(1'b1, 1'b1, mk(0, 1, 9'd99), "full push");
        for (int i = 0; i < DP; i++) begin
            op(1'b1, 1'b0, '0, "drain");
            check("drain order", 32'(variable_out), 32'(DP - 1 - i));
        end
        op(1'b1, 1'b0, '0, "pop after drain");
        check("pop after drain var", 32'(variable_out), 32'd0);

        // Reset mid-sequence
        op(1'b1, 1'b1, mk(1, 1, 9'd10), "pre-reset push");
        op(1'b1, 1'b1, mk(0, 0, 9'd11), "pre-reset push");
        op(1'b1, 1'b1, mk(1, 0, 9'd12), "pre-reset push");
        op(1'b1, 1'b0, '0, "pre-reset pop");
        apply_reset(1);
        check("mid reset empty", 32'(empty), 32'd1);
        check("mid reset out", 32'({type_out, val_out, variable_out}), 32'd0);
        op(1'b1, 1'b0, '0, "pop after reset");
        check("pop after reset out", 32'({type_out, val_out, variable_out}), 32'd0);
        op(1'b0, 1'b1, mk(1, 1, 9'd300), "idle rw1");
        op(1'b0, 1'b0, mk(1, 1, 9'd301), "idle rw0");
        op(1'b0, 1'b1, mk(1, 1, 9'd302), "idle rw1");
        check("idle empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
